instr_decode_stage: RTL and testbench

Registered, handshaked instruction decode stage for the 5-stage pipeline, sitting between the fetch/IF-ID latch and the register-file read / ID-EX latch. It is the parametrised successor of the flat opcode one-hot decoder. It accepts a raw instruction word plus PC, decodes opcode class, register specifiers, immediate and jump target, and presents them one cycle later. Backpressure is handled through a two-entry skid buffer, and a flush input squashes in-flight entries on a taken branch or jump.

---
 rtl/isa_pkg.sv | 61 ++++++
 rtl/instr_decode_stage_if.sv | 48 ++++
 rtl/insn_field_decode.sv | 61 ++++++
 rtl/instr_decode_stage.sv | 94 +++++++++
 tb/tb_instr_decode_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, field offsets,
// class indices and the decoded bundle. Optional DECODE_ILLEGAL_TRAP_EN adds the illegal flag.
package isa_pkg;

    localparam int ISA_INSN_W = 32;
    localparam int ISA_OP_W   = 5;
    localparam int ISA_REG_W  = 5;
    localparam int ISA_IMM_W  = 17;
    localparam int ISA_DATA_W = 32;
    localparam int ISA_PC_W   = 32;

    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int SUBFLD_W  = 5;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_RI   = 5'b01011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    localparam logic [ISA_REG_W-1:0] RA      = 5'd31;
    localparam logic [ISA_REG_W-1:0] RSTATUS = 5'd30;

    typedef enum logic [3:0] {
        CLS_R, CLS_J, CLS_BNE, CLS_JAL, CLS_JR, CLS_ADDI,
        CLS_BLT, CLS_SW, CLS_LW, CLS_RI, CLS_SETX, CLS_BEX
    } class_idx_e;

    localparam int NUM_CLASS = 12;

    typedef struct packed {
        logic [ISA_PC_W-1:0]   pc;
        logic [NUM_CLASS-1:0]  cls;
        logic [ISA_REG_W-1:0]  rd;
        logic [ISA_REG_W-1:0]  rs1;
        logic [ISA_REG_W-1:0]  rs2;
        logic [4:0]            aluop;
        logic [4:0]            shamt;
        logic [ISA_DATA_W-1:0] imm;
        logic [ISA_PC_W-1:0]   target;
        logic                  reg_we;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic                  illegal;
`endif
    } bundle_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage.
// out_illegal exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface instr_decode_stage_if #(
    parameter int INSN_W    = 32,
    parameter int REG_W     = 5,
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int NUM_CLASS = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [INSN_W-1:0] in_insn;
    logic [PC_W-1:0]   in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [PC_W-1:0]      out_pc;
    logic [NUM_CLASS-1:0] out_class;
    logic [REG_W-1:0]     out_rd;
    logic [REG_W-1:0]     out_rs1;
    logic [REG_W-1:0]     out_rs2;
    logic [4:0]           out_aluop;
    logic [4:0]           out_shamt;
    logic [DATA_W-1:0]    out_imm;
    logic [PC_W-1:0]      out_target;
    logic                 out_reg_we;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                 out_illegal;
`endif

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_class, out_rd, out_rs1, out_rs2,
               out_aluop, out_shamt, out_imm, out_target, out_reg_we
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_class, out_rd, out_rs1, out_rs2,
               out_aluop, out_shamt, out_imm, out_target, out_reg_we
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output out_illegal
`endif
    );
endinterface

// File: rtl/insn_field_decode.sv
// Combinational raw instruction word -> decoded bundle.
// Undefined opcodes give an empty class and no write; DECODE_ILLEGAL_TRAP_EN also flags them.
module insn_field_decode
    import isa_pkg::*;
#(
    parameter int INSN_W = ISA_INSN_W,
    parameter int OP_W   = ISA_OP_W,
    parameter int REG_W  = ISA_REG_W,
    parameter int IMM_W  = ISA_IMM_W,
    parameter int DATA_W = ISA_DATA_W,
    parameter int PC_W   = ISA_PC_W
) (
    input  logic [INSN_W-1:0] insn_i,
    input  logic [PC_W-1:0]   pc_i,
    output bundle_t           bundle_o
);
    logic [OP_W-1:0] opcode;
    logic [REG_W-1:0] rd_field;

    always_comb begin
        opcode   = insn_i[INSN_W-1 -: OP_W];
        rd_field = insn_i[RD_LSB +: REG_W];

        bundle_o        = '0;
        bundle_o.pc     = pc_i;
        bundle_o.rd     = rd_field;
        bundle_o.rs1    = insn_i[RS_LSB +: REG_W];
        bundle_o.rs2    = insn_i[RT_LSB +: REG_W];
        bundle_o.shamt  = insn_i[SHAMT_LSB +: SUBFLD_W];
        bundle_o.imm    = {{(DATA_W-IMM_W){insn_i[IMM_W-1]}}, insn_i[IMM_W-1:0]};
        bundle_o.target = {{(PC_W-(INSN_W-OP_W)){1'b0}}, insn_i[INSN_W-OP_W-1:0]};

        case (opcode)
            OP_R:    begin bundle_o.cls[CLS_R] = 1'b1; bundle_o.reg_we = 1'b1;
                           bundle_o.aluop = insn_i[ALUOP_LSB +: SUBFLD_W]; end
            OP_J:    bundle_o.cls[CLS_J] = 1'b1;
            OP_BNE:  begin bundle_o.cls[CLS_BNE] = 1'b1; bundle_o.rs2 = rd_field;
                           bundle_o.aluop = ALU_SUB; end
            OP_JAL:  begin bundle_o.cls[CLS_JAL] = 1'b1; bundle_o.rd = RA;
                           bundle_o.reg_we = 1'b1; end
            OP_JR:   begin bundle_o.cls[CLS_JR] = 1'b1; bundle_o.rs2 = rd_field; end
            OP_ADDI: begin bundle_o.cls[CLS_ADDI] = 1'b1; bundle_o.reg_we = 1'b1;
                           bundle_o.aluop = ALU_ADD; end
            OP_BLT:  begin bundle_o.cls[CLS_BLT] = 1'b1; bundle_o.rs2 = rd_field;
                           bundle_o.aluop = ALU_SUB; end
            OP_SW:   begin bundle_o.cls[CLS_SW] = 1'b1; bundle_o.rs2 = rd_field;
                           bundle_o.aluop = ALU_ADD; end
            OP_LW:   begin bundle_o.cls[CLS_LW] = 1'b1; bundle_o.reg_we = 1'b1;
                           bundle_o.aluop = ALU_ADD; end
            OP_RI:   begin bundle_o.cls[CLS_RI] = 1'b1; bundle_o.reg_we = 1'b1; end
            OP_SETX: begin bundle_o.cls[CLS_SETX] = 1'b1; bundle_o.rd = RSTATUS;
                           bundle_o.reg_we = 1'b1; end
            OP_BEX:  begin bundle_o.cls[CLS_BEX] = 1'b1; bundle_o.rs1 = RSTATUS; end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                bundle_o.illegal = 1'b1;
`endif
            end
        endcase
    end
endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decoder on the input side, OUT register plus one skid entry.
// DECODE_ILLEGAL_TRAP_EN enables the out_illegal flag.
module instr_decode_stage
    import isa_pkg::*;
#(
    parameter int INSN_W = ISA_INSN_W,
    parameter int OP_W   = ISA_OP_W,
    parameter int REG_W  = ISA_REG_W,
    parameter int IMM_W  = ISA_IMM_W,
    parameter int DATA_W = ISA_DATA_W,
    parameter int PC_W   = ISA_PC_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus
);
    bundle_t dec;
    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept;

    insn_field_decode #(
        .INSN_W(INSN_W), .OP_W(OP_W), .REG_W(REG_W),
        .IMM_W(IMM_W), .DATA_W(DATA_W), .PC_W(PC_W)
    ) u_decode (
        .insn_i   (bus.in_insn),
        .pc_i     (bus.in_pc),
        .bundle_o (dec)
    );

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        accept       = bus.in_valid & in_ready_q & ~flush;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = dec;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end

        // registered so in_ready never depends combinationally on out_ready
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = out_q.pc;
    assign bus.out_class  = out_q.cls;
    assign bus.out_rd     = out_q.rd;
    assign bus.out_rs1    = out_q.rs1;
    assign bus.out_rs2    = out_q.rs2;
    assign bus.out_aluop  = out_q.aluop;
    assign bus.out_shamt  = out_q.shamt;
    assign bus.out_imm    = out_q.imm;
    assign bus.out_target = out_q.target;
    assign bus.out_reg_we = out_q.reg_we;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.out_illegal = out_q.illegal;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus random traffic against
// a queue-based occupancy model with an arithmetic decode reference.
module tb_instr_decode_stage;
    logic clock = 1'b0;
    logic reset, flush;
    always #5 clock = ~clock;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [11:0] cls;
        logic [4:0]  rd, rs1, rs2, aluop, shamt;
        logic [31:0] imm, target;
        logic        we, ill;
    } exp_t;

    exp_t q[$];
    bit   m_rdy;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc);
        exp_t e;
        int op, rd, rs, rt, idx;
        longint raw;
        op = int'(insn >> 27);
        rd = int'((insn >> 22) & 32'd31);
        rs = int'((insn >> 17) & 32'd31);
        rt = int'((insn >> 12) & 32'd31);
        case (op)
            0: idx = 0;   1: idx = 1;   2: idx = 2;   3: idx = 3;
            4: idx = 4;   5: idx = 5;   6: idx = 6;   7: idx = 7;
            8: idx = 8;   11: idx = 9;  21: idx = 10; 22: idx = 11;
            default: idx = -1;
        endcase
        e.pc    = pc;
        e.cls   = (idx >= 0) ? 12'(1 << idx) : 12'd0;
        e.ill   = (idx < 0);
        e.rd    = (op == 3) ? 5'd31 : (op == 21) ? 5'd30 : 5'(rd);
        e.rs1   = (op == 22) ? 5'd30 : 5'(rs);
        e.rs2   = (op == 7 || op == 2 || op == 6 || op == 4) ? 5'(rd) : 5'(rt);
        e.shamt = 5'((insn >> 7) & 32'd31);
        if (op == 0)                             e.aluop = 5'((insn >> 2) & 32'd31);
        else if (op == 2 || op == 6)             e.aluop = 5'd1;
        else                                     e.aluop = 5'd0;
        e.we    = (op == 0 || op == 5 || op == 8 || op == 3 || op == 21 || op == 11);
        raw = longint'(insn & 32'h1FFFF);
        if (raw >= 'h10000) raw = raw - 'h20000;
        e.imm    = raw[31:0];
        e.target = insn & 32'h07FF_FFFF;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_rdy = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rdy = 1'b1;
        end else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && m_rdy) q.push_back(ref_decode(bus.in_insn, bus.in_pc));
            m_rdy = (q.size() < 2);
        end
        #1;
        check_val("out_valid", bus.out_valid, q.size() > 0);
        check_val("in_ready", bus.in_ready, m_rdy);
        if (reset) begin
            check_val("rst_out_pc", bus.out_pc, 0);
            check_val("rst_out_class", bus.out_class, 0);
            check_val("rst_out_imm", bus.out_imm, 0);
            check_val("rst_out_reg_we", bus.out_reg_we, 0);
        end else if (q.size() > 0) begin
            check_val("out_pc", bus.out_pc, q[0].pc);
            check_val("out_class", bus.out_class, q[0].cls);
            check_val("out_rd", bus.out_rd, q[0].rd);
            check_val("out_rs1", bus.out_rs1, q[0].rs1);
            check_val("out_rs2", bus.out_rs2, q[0].rs2);
            check_val("out_aluop", bus.out_aluop, q[0].aluop);
            check_val("out_shamt", bus.out_shamt, q[0].shamt);
            check_val("out_imm", bus.out_imm, q[0].imm);
            check_val("out_target", bus.out_target, q[0].target);
            check_val("out_reg_we", bus.out_reg_we, q[0].we);
`ifdef DECODE_ILLEGAL_TRAP_EN
            check_val("out_illegal", bus.out_illegal, q[0].ill);
`endif
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                         input bit rdy, input bit fl, input bit rst);
        bus.in_valid  = v;
        bus.in_insn   = insn;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        flush         = fl;
        reset         = rst;
        step();
    endtask

    int legal_ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 21, 22};

    initial begin
        logic [31:0] r, insn;
        int op;
        m_rdy = 1'b0;

        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        check_val("rst_hold_in_ready", bus.in_ready, 0);
        drive(0, 0, 0, 1, 0, 0);
        check_val("post_rst_in_ready", bus.in_ready, 1);

        drive(1, 32'h28C3FFFB, 32'h40, 1, 0, 0);
        check_val("addi_valid", bus.out_valid, 1);
        check_val("addi_class", bus.out_class, 12'h020);
        check_val("addi_rd", bus.out_rd, 3);
        check_val("addi_rs1", bus.out_rs1, 1);
        check_val("addi_imm", bus.out_imm, 32'hFFFFFFFB);
        check_val("addi_we", bus.out_reg_we, 1);
        check_val("addi_pc", bus.out_pc, 32'h40);
        drive(1, 32'h18000100, 32'h44, 1, 0, 0);
        check_val("jal_rd", bus.out_rd, 31);
        check_val("jal_target", bus.out_target, 32'h100);
        check_val("jal_we", bus.out_reg_we, 1);
        drive(1, 32'h39440004, 32'h48, 1, 0, 0);
        check_val("sw_rs2", bus.out_rs2, 5);
        check_val("sw_rs1", bus.out_rs1, 2);
        check_val("sw_we", bus.out_reg_we, 0);
        drive(0, 0, 0, 1, 0, 0);

        // backpressure: A held, B skidded, C waits, then A B C back to back
        drive(1, 32'h28000001, 32'h100, 0, 0, 0);
        drive(1, 32'h28000002, 32'h104, 0, 0, 0);
        drive(1, 32'h28000003, 32'h108, 0, 0, 0);
        check_val("bp_in_ready", bus.in_ready, 0);
        check_val("bp_hold_a", bus.out_pc, 32'h100);
        drive(1, 32'h28000003, 32'h108, 0, 0, 0);
        check_val("bp_hold_a2", bus.out_pc, 32'h100);
        drive(1, 32'h28000003, 32'h108, 1, 0, 0);
        check_val("bp_out_b", bus.out_pc, 32'h104);
        drive(1, 32'h28000003, 32'h108, 1, 0, 0);
        check_val("bp_out_c", bus.out_pc, 32'h108);
        check_val("bp_c_valid", bus.out_valid, 1);
        drive(0, 0, 0, 1, 0, 0);

        drive(1, 32'h28000011, 32'h200, 0, 0, 0);
        drive(1, 32'h28000012, 32'h204, 0, 0, 0);
        check_val("fl_full", bus.in_ready, 0);
        drive(1, 32'h28000013, 32'h208, 0, 1, 0);
        check_val("fl_out_valid", bus.out_valid, 0);
        check_val("fl_in_ready", bus.in_ready, 1);
        drive(0, 0, 0, 1, 0, 0);
        check_val("fl_empty", bus.out_valid, 0);

        drive(1, 32'hF8000000, 32'h300, 1, 0, 0);
        check_val("ill_valid", bus.out_valid, 1);
        check_val("ill_class", bus.out_class, 0);
        check_val("ill_we", bus.out_reg_we, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check_val("ill_flag", bus.out_illegal, 1);
`endif
        drive(0, 0, 0, 1, 0, 0);

        drive(1, 32'h28C3FFFB, 32'h400, 0, 0, 0);
        check_val("mid_valid", bus.out_valid, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_val("mid_rst_valid", bus.out_valid, 0);
        check_val("mid_rst_ready", bus.in_ready, 0);
        drive(0, 0, 0, 1, 0, 0);
        check_val("mid_rel_ready", bus.in_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom();
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                             : legal_ops[$urandom_range(0, 11)];
            insn = {op[4:0], r[26:0]};
            drive($urandom_range(0, 99) < 70, insn, $urandom(),
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
